// File: rtl/mba_gpio_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mba_gpio_tx_if
// Description : Valid/ready product-word handshake between the MBA multiplier
//               core (master) and the GPIO transmitter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mba_gpio_tx_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mba_gpio_tx.sv
`default_nettype none
// ============================================================================
// Module      : mba_gpio_tx
// Description : GPIO output transmitter for the MBA multiplier. Buffers product
//               words in a small FIFO and drives each one on the GPIO data bus
//               for HOLD_CYCLES with a strobe, followed by GAP_CYCLES of idle.
//               Optional macro MBA_GPIO_TX_PARITY_EN adds a registered even
//               parity pin and widens gpio_oeb by one bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mba_gpio_tx #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  wire logic              wb_clk_i,
    input  wire logic              wb_rst_i,
    mba_gpio_tx_if.slave           s_in,
    input  wire logic              flush,
    output logic [DATA_W-1:0]      gpio_data,
    output logic                   gpio_strobe,
`ifdef MBA_GPIO_TX_PARITY_EN
    output logic                   gpio_parity,
    output logic [DATA_W+1:0]      gpio_oeb,
`else
    output logic [DATA_W:0]        gpio_oeb,
`endif
    output logic                   busy,
    output logic [7:0]             tx_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW       = $clog2(FIFO_DEPTH);
    localparam int c_GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int c_CNT_MAX  = (HOLD_CYCLES - 1 > c_GAP_LOAD) ? HOLD_CYCLES - 1 : c_GAP_LOAD;
    localparam int c_CNT_W    = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);
`ifdef MBA_GPIO_TX_PARITY_EN
    localparam int c_OEB_W    = DATA_W + 2;
`else
    localparam int c_OEB_W    = DATA_W + 1;
`endif

    localparam logic [c_AW:0]    c_PTR_ONE   = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD_V = c_CNT_W'(c_GAP_LOAD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  w_data_nxt;
    logic               r_strobe;
    logic               w_strobe_nxt;
    logic               w_tx_inc;
    logic [7:0]         r_tx_count;
    logic [c_OEB_W-1:0] r_oeb;

    // ------------------------------------------------------------------------
    // FIFO status: full when the wrap bits differ but the index bits match
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // in_ready looks only at registered occupancy, so a pop in the same cycle
    // never opens the door early. flush drops any same-cycle push.
    assign s_in.in_ready = !w_full;
    assign w_push        = s_in.in_valid && !w_full && !flush;

    // FIFO storage: written on push, no reset needed for data contents
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= s_in.in_data;
        end
    end

    // FIFO pointers: advance on push/pop, cleared by reset or flush
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    // FSM next-state and bus register updates; flush overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_strobe_nxt = r_strobe;
        w_pop        = 1'b0;
        w_tx_inc     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_data_nxt   = r_mem[r_rd_ptr[c_AW-1:0]];
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = c_HOLD_LOAD;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_tx_inc     = 1'b1;
                    w_data_nxt   = '0;
                    w_strobe_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_cnt_nxt   = c_GAP_LOAD_V;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_data_nxt   = '0;
                w_strobe_nxt = 1'b0;
            end
        endcase

        // An abandoned word is neither popped further nor counted
        if (flush) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_data_nxt   = '0;
            w_strobe_nxt = 1'b0;
            w_pop        = 1'b0;
            w_tx_inc     = 1'b0;
        end
    end

    // FSM state, counter and bus registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    // Completed-word counter; wraps naturally at 8 bits, untouched by flush
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tx_count <= 8'd0;
        end else if (w_tx_inc) begin
            r_tx_count <= r_tx_count + 8'd1;
        end
    end

    // Pads stay tri-stated during reset and enable on the first edge after it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_oeb <= '1;
        end else begin
            r_oeb <= '0;
        end
    end

`ifdef MBA_GPIO_TX_PARITY_EN
    logic r_parity;

    // Parity bit registered with the data so both change on the same edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_data_nxt;
        end
    end

    assign gpio_parity = r_parity;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gpio_data   = r_data;
    assign gpio_strobe = r_strobe;
    assign gpio_oeb    = r_oeb;
    assign tx_count    = r_tx_count;
    assign busy        = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mba_gpio_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mba_gpio_tx
// Description : Directed self-checking bench for mba_gpio_tx. Instance A uses
//               the default timing (HOLD 8, GAP 2); instance B uses GAP 0.
//               Honours MBA_GPIO_TX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mba_gpio_tx;

`ifdef MBA_GPIO_TX_PARITY_EN
    localparam int c_OEB_W = 18;
`else
    localparam int c_OEB_W = 17;
`endif

    logic                clk;
    logic                rst;
    logic                flush_a;
    logic                flush_b;
    logic [15:0]         data_a, data_b;
    logic                strobe_a, strobe_b;
    logic [c_OEB_W-1:0]  oeb_a, oeb_b;
    logic                busy_a, busy_b;
    logic [7:0]          txc_a, txc_b;
`ifdef MBA_GPIO_TX_PARITY_EN
    logic                par_a, par_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mba_gpio_tx_if #(.DATA_W(16)) if_a ();
    mba_gpio_tx_if #(.DATA_W(16)) if_b ();

    mba_gpio_tx #(.DATA_W(16), .FIFO_DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(2)) u_dut_a (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .s_in        (if_a.slave),
        .flush       (flush_a),
        .gpio_data   (data_a),
        .gpio_strobe (strobe_a),
`ifdef MBA_GPIO_TX_PARITY_EN
        .gpio_parity (par_a),
`endif
        .gpio_oeb    (oeb_a),
        .busy        (busy_a),
        .tx_count    (txc_a)
    );

    mba_gpio_tx #(.DATA_W(16), .FIFO_DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(0)) u_dut_b (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .s_in        (if_b.slave),
        .flush       (flush_b),
        .gpio_data   (data_b),
        .gpio_strobe (strobe_b),
`ifdef MBA_GPIO_TX_PARITY_EN
        .gpio_parity (par_b),
`endif
        .gpio_oeb    (oeb_b),
        .busy        (busy_b),
        .tx_count    (txc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts idle negedges until the strobe rises, then checks the 8-cycle hold window
    task automatic mon_word(input bit use_b, input logic [15:0] w, input int exp_gap);
        int z;
        z = 0;
        @(negedge clk);
        while (!(use_b ? strobe_b : strobe_a) && z < 60) begin
            z++;
            @(negedge clk);
        end
        check("gap_len", z, exp_gap);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_word", use_b ? {strobe_b, data_b} : {strobe_a, data_a}, {1'b1, w});
`ifdef MBA_GPIO_TX_PARITY_EN
            if (!use_b) check("parity_hold", par_a, ^w);
`endif
        end
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", busy_a, 0);
    endtask

    logic [15:0] burst [5];
    bit          seen;
    bit          done;
    int          pushed;
    bit          rdy;

    initial begin
        burst[0] = 16'h0005; burst[1] = 16'h0036; burst[2] = 16'h0019;
        burst[3] = 16'h0DE3; burst[4] = 16'h0980;
        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_data = '0;
        if_b.in_valid = 1'b0; if_b.in_data = '0;

        // ---------------- reset, before any clock edge ----------------
        #3;
        check("rst_data", data_a, 0);
        check("rst_strobe", strobe_a, 0);
        check("rst_oeb", oeb_a, {c_OEB_W{1'b1}});
        check("rst_busy", busy_a, 0);
        check("rst_txc", txc_a, 0);
        check("rst_ready", if_a.in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check("oeb_before_edge", oeb_a, {c_OEB_W{1'b1}});
        @(negedge clk);
        check("oeb_after_edge", oeb_a, 0);
        check("oeb_b_after_edge", oeb_b, 0);

        // ---------------- single word ----------------
        // in_valid rises in cycle t, push on the following edge, word visible one edge later
        if_a.in_valid = 1'b1; if_a.in_data = 16'h0383;
        fork
            begin @(posedge clk); #1 if_a.in_valid = 1'b0; end
            mon_word(0, 16'h0383, 1);
        join
        @(negedge clk);
        check("single_gap0", {strobe_a, data_a}, 0);
        check("single_txc", txc_a, 1);
        check("single_busy_gap", busy_a, 1);
        @(negedge clk);
        check("single_gap1", {strobe_a, data_a}, 0);
        check("single_busy_gap1", busy_a, 1);
        @(negedge clk);
        check("single_busy_idle", busy_a, 0);

        // ---------------- back-to-back burst ----------------
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    if_a.in_data = burst[i]; if_a.in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                if_a.in_valid = 1'b0;
                @(negedge clk);
                check("burst_full_ready", if_a.in_ready, 0);
                check("burst_busy", busy_a, 1);
            end
            begin
                mon_word(0, burst[0], 1);
                for (int i = 1; i < 5; i++) mon_word(0, burst[i], 3);
            end
        join
        @(negedge clk);
        check("burst_end", {strobe_a, data_a}, 0);
        check("burst_txc", txc_a, 6);
        wait_idle_a();

        // ---------------- GAP_CYCLES = 0 instance ----------------
        fork
            begin
                if_b.in_data = 16'h0A0A; if_b.in_valid = 1'b1;
                @(posedge clk); #1;
                if_b.in_data = 16'h0B0B;
                @(posedge clk); #1;
                if_b.in_valid = 1'b0;
            end
            begin
                mon_word(1, 16'h0A0A, 1);
                mon_word(1, 16'h0B0B, 1);
            end
        join
        @(negedge clk);
        check("gap0_end", {strobe_b, data_b}, 0);
        check("gap0_txc", txc_b, 2);

        // ---------------- flush in third HOLD cycle ----------------
        @(negedge clk);
        if_a.in_data = 16'h06CF; if_a.in_valid = 1'b1;
        @(posedge clk); #1 if_a.in_data = 16'h1111;
        @(posedge clk); #1 if_a.in_data = 16'h2222;
        @(negedge clk);
        check("flush_hold1", {strobe_a, data_a}, {1'b1, 16'h06CF});
        @(posedge clk); #1 if_a.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush_hold3", {strobe_a, data_a}, {1'b1, 16'h06CF});
        flush_a = 1'b1; if_a.in_valid = 1'b1; if_a.in_data = 16'h3333;
        @(posedge clk); #1;
        flush_a = 1'b0; if_a.in_valid = 1'b0;
        @(negedge clk);
        check("flush_bus", {strobe_a, data_a}, 0);
        check("flush_busy", busy_a, 0);
        check("flush_ready", if_a.in_ready, 1);
        check("flush_txc", txc_a, 6);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (strobe_a || data_a != 0) seen = 1'b1;
        end
        check("flush_no_word", seen, 0);
        check("flush_txc_later", txc_a, 6);

`ifdef MBA_GPIO_TX_PARITY_EN
        // ---------------- parity ----------------
        fork
            begin
                if_a.in_data = 16'h0C96; if_a.in_valid = 1'b1;
                @(posedge clk); #1 if_a.in_data = 16'h0982;
                @(posedge clk); #1 if_a.in_data = 16'h0007;
                @(posedge clk); #1 if_a.in_valid = 1'b0;
            end
            begin
                mon_word(0, 16'h0C96, 1);
                @(negedge clk);
                check("parity_gap", par_a, 0);
                mon_word(0, 16'h0982, 2);
                mon_word(0, 16'h0007, 3);
            end
        join
        @(negedge clk);
        check("parity_gap_end", par_a, 0);
        wait_idle_a();
`endif

        // ---------------- reset mid-transfer ----------------
        if_a.in_data = 16'h1234; if_a.in_valid = 1'b1;
        @(posedge clk); #1 if_a.in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("pre_rst_strobe", strobe_a, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bus", {strobe_a, data_a}, 0);
        check("mid_rst_oeb", oeb_a, {c_OEB_W{1'b1}});
        check("mid_rst_txc", txc_a, 0);
        check("mid_rst_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_oeb", oeb_a, 0);
        check("post_rst_ready", if_a.in_ready, 1);

        // ---------------- tx_count wrap after 256 words ----------------
        done = 1'b0; seen = 1'b0; pushed = 0;
        fork
            begin
                while (pushed < 256) begin
                    @(negedge clk);
                    if_a.in_valid = 1'b1; if_a.in_data = 16'(pushed);
                    rdy = if_a.in_ready;
                    @(posedge clk); #1;
                    if (rdy) pushed++;
                end
                if_a.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 3500; i++) begin
                    @(negedge clk);
                    if (txc_a == 8'd255) seen = 1'b1;
                    if (done && !busy_a) break;
                end
                if (!done) begin
                    $display("FAIL wrap_timeout: observed pushes %0d expected 256", pushed);
                    n_errors++;
                    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                    $fatal(1, "wrap stalled");
                end
            end
        join
        check("wrap_seen_255", seen, 1);
        check("wrap_txc", txc_a, 0);
        check("wrap_busy", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
